// File: rtl/hub75_rx.sv
// hub75_rx: HUB75 panel-bus receiver. Oversamples the panel interface,
// captures shifted rows into a ping-pong line buffer and replays each
// latched row as a one-pixel-per-cycle frame-memory write stream.
module hub75_rx #(
    parameter int unsigned COLS  = 64,
    parameter int unsigned COL_W = 6,
    parameter int unsigned ROW_W = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_hub_clk,
    input  logic                   i_hub_latch,
    input  logic                   i_hub_blank,
    input  logic [1:0]             i_hub_r,
    input  logic [1:0]             i_hub_g,
    input  logic [1:0]             i_hub_b,
    input  logic [ROW_W-1:0]       i_hub_row,
    output logic                   o_wr_en,
    output logic [ROW_W+COL_W-1:0] o_wr_addr,
    output logic [5:0]             o_wr_data,
    output logic                   o_row_done,
    output logic [ROW_W-1:0]       o_row_idx,
    output logic                   o_blank,
    output logic [2:0]             o_err
);

    // Column count needs one extra bit so it can hold COLS itself.
    localparam int unsigned CNT_W  = COL_W + 1;
    localparam int unsigned AW     = ROW_W + COL_W;
    localparam int unsigned SYNC_W = ROW_W + 9;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Synchronizer vector layout: {clk, latch, blank, rgb[5:0], row}.
    logic [SYNC_W-1:0] w_sync_in;
    logic [SYNC_W-1:0] r_s1;
    logic [SYNC_W-1:0] r_s2;
    logic              r_clk_d;
    logic              r_lat_d;

    logic [CNT_W-1:0]  r_col;
    logic              r_act;
    logic [1:0]        r_pend;
    logic [ROW_W-1:0]  r_tag [0:1];
    logic [CNT_W-1:0]  r_n   [0:1];
    logic [5:0]        r_bank [0:1][0:COLS-1];
    logic [2:0]        r_err;

    state_t            r_state;
    state_t            w_state_nx;
    logic              r_cbank;
    logic              w_cbank_nx;
    logic [COL_W-1:0]  r_k;
    logic [COL_W-1:0]  w_k_nx;
    logic              w_wr_en_nx;
    logic [AW-1:0]     w_wr_addr_nx;
    logic [5:0]        w_wr_data_nx;
    logic              w_done_nx;
    logic              w_release;

    logic              w_s_clk;
    logic              w_s_lat;
    logic [5:0]        w_s_rgb;
    logic [ROW_W-1:0]  w_s_row;
    logic              w_clk_rise;
    logic              w_lat_rise;
    logic              w_cap;
    logic              w_ovf;
    logic [CNT_W-1:0]  w_n;
    logic              w_other_busy;
    logic              w_commit;
    logic              w_overrun;
    logic              w_short;

    assign w_sync_in = {i_hub_clk, i_hub_latch, i_hub_blank,
                        i_hub_r[1], i_hub_g[1], i_hub_b[1],
                        i_hub_r[0], i_hub_g[0], i_hub_b[0], i_hub_row};

    assign w_s_row = r_s2[ROW_W-1:0];
    assign w_s_rgb = r_s2[ROW_W+5:ROW_W];
    assign w_s_lat = r_s2[ROW_W+7];
    assign w_s_clk = r_s2[ROW_W+8];
    assign o_blank = r_s2[ROW_W+6];

    // A pixel arriving together with the latch belongs to the row being closed.
    assign w_clk_rise   = w_s_clk & ~r_clk_d;
    assign w_lat_rise   = w_s_lat & ~r_lat_d;
    assign w_cap        = w_clk_rise && (r_col < CNT_W'(COLS));
    assign w_ovf        = w_clk_rise && !w_cap;
    assign w_n          = w_cap ? (r_col + CNT_W'(1)) : r_col;
    assign w_other_busy = r_pend[~r_act];
    assign w_commit     = w_lat_rise && (w_n != '0) && !w_other_busy;
    assign w_overrun    = w_lat_rise && (w_n != '0) && w_other_busy;
    // A dropped row is reported only as an overrun.
    assign w_short      = w_commit && (w_n < CNT_W'(COLS));

    // Two-flop synchronizers plus edge-detect history.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1    <= '0;
            r_s2    <= '0;
            r_clk_d <= 1'b0;
            r_lat_d <= 1'b0;
        end else begin
            r_s1    <= w_sync_in;
            r_s2    <= r_s1;
            r_clk_d <= w_s_clk;
            r_lat_d <= w_s_lat;
        end
    end

    // Column counter, active bank select and per-bank row tag / count.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_col    <= '0;
            r_act    <= 1'b0;
            r_tag[0] <= '0;
            r_tag[1] <= '0;
            r_n[0]   <= '0;
            r_n[1]   <= '0;
        end else begin
            if (w_lat_rise) begin
                r_col <= '0;
                if (w_commit) begin
                    r_act        <= ~r_act;
                    r_tag[r_act] <= w_s_row;
                    r_n[r_act]   <= w_n;
                end
            end else if (w_cap) begin
                r_col <= r_col + CNT_W'(1);
            end
        end
    end

    // Line-buffer storage; contents are don't-care until a row is captured.
    always_ff @(posedge i_clk) begin
        if (w_cap) begin
            r_bank[r_act][r_col[COL_W-1:0]] <= w_s_rgb;
        end
    end

    // Pending flags: set on commit of the filled bank, cleared when its replay ends.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pend <= 2'b00;
        end else begin
            if (w_release) begin
                r_pend[r_cbank] <= 1'b0;
            end
            if (w_commit) begin
                r_pend[r_act] <= 1'b1;
            end
        end
    end

    // Sticky error flags.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_err <= '0;
        end else begin
            r_err <= r_err | {w_overrun, w_short, w_ovf};
        end
    end

    assign o_err = r_err;

    // Commit FSM state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_cbank <= 1'b0;
            r_k     <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cbank <= w_cbank_nx;
            r_k     <= w_k_nx;
        end
    end

    // Commit FSM next-state and write-port values.
    always_comb begin
        w_state_nx   = r_state;
        w_cbank_nx   = r_cbank;
        w_k_nx       = r_k;
        w_wr_en_nx   = 1'b0;
        w_wr_addr_nx = '0;
        w_wr_data_nx = '0;
        w_done_nx    = 1'b0;
        w_release    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_pend != 2'b00) begin
                    w_state_nx = S_WRITE;
                    w_cbank_nx = ~r_pend[0];
                    w_k_nx     = '0;
                end
            end
            S_WRITE: begin
                w_wr_en_nx   = 1'b1;
                w_wr_addr_nx = {r_tag[r_cbank], r_k};
                w_wr_data_nx = r_bank[r_cbank][r_k];
                if ((CNT_W'(r_k) + CNT_W'(1)) == r_n[r_cbank]) begin
                    w_state_nx = S_DONE;
                end else begin
                    w_k_nx = r_k + COL_W'(1);
                end
            end
            S_DONE: begin
                w_done_nx  = 1'b1;
                w_release  = 1'b1;
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // Registered write port and row-done report.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_wr_en    <= 1'b0;
            o_wr_addr  <= '0;
            o_wr_data  <= '0;
            o_row_done <= 1'b0;
            o_row_idx  <= '0;
        end else begin
            o_wr_en    <= w_wr_en_nx;
            o_wr_addr  <= w_wr_addr_nx;
            o_wr_data  <= w_wr_data_nx;
            o_row_done <= w_done_nx;
            if (w_done_nx) begin
                o_row_idx <= r_tag[r_cbank];
            end
        end
    end

endmodule

// File: tb/tb_hub75_rx.sv
// tb_hub75_rx: drives HUB75 rows into hub_rx and scoreboards the write stream.
module tb_hub75_rx;

    localparam int unsigned COLS  = 64;
    localparam int unsigned COL_W = 6;
    localparam int unsigned ROW_W = 4;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   hub_clk = 1'b0;
    logic                   hub_latch = 1'b0;
    logic                   hub_blank = 1'b0;
    logic [1:0]             hub_r = '0;
    logic [1:0]             hub_g = '0;
    logic [1:0]             hub_b = '0;
    logic [ROW_W-1:0]       hub_row = '0;
    logic                   wr_en;
    logic [ROW_W+COL_W-1:0] wr_addr;
    logic [5:0]             wr_data;
    logic                   row_done;
    logic [ROW_W-1:0]       row_idx;
    logic                   blank;
    logic [2:0]             err;

    int checks = 0;
    int errors = 0;
    int n_wr   = 0;
    bit [15:0] sbw[$];
    bit [3:0]  sbd[$];

    hub75_rx #(.COLS(COLS), .COL_W(COL_W), .ROW_W(ROW_W)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_hub_clk(hub_clk), .i_hub_latch(hub_latch), .i_hub_blank(hub_blank),
        .i_hub_r(hub_r), .i_hub_g(hub_g), .i_hub_b(hub_b), .i_hub_row(hub_row),
        .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
        .o_row_done(row_done), .o_row_idx(row_idx), .o_blank(blank), .o_err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int       n;
        bit [3:0] row;
        int       seed;
        bit [2:0] err;
    } vec_t;

    function automatic bit [5:0] pix(input int c, input int s);
        return 6'(c + s);
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_rgb(input bit [5:0] d);
        hub_r = {d[5], d[2]};
        hub_g = {d[4], d[1]};
        hub_b = {d[3], d[0]};
    endtask

    task automatic drive_pix(input bit [5:0] d, input int hp);
        hub_clk = 1'b0;
        set_rgb(d);
        step(hp);
        hub_clk = 1'b1;
        step(hp);
    endtask

    task automatic shift_row(input int n, input int seed, input int hp);
        for (int c = 0; c < n; c++) drive_pix(pix(c, seed), hp);
    endtask

    task automatic do_latch(input bit [3:0] row, input int hp);
        hub_clk = 1'b0;
        step(hp);
        hub_latch = 1'b1;
        hub_row   = row;
        step(hp);
        hub_latch = 1'b0;
        step(hp);
    endtask

    task automatic push_row(input bit [3:0] row, input int n, input int seed);
        int m;
        m = (n > int'(COLS)) ? int'(COLS) : n;
        for (int k = 0; k < m; k++) sbw.push_back({row, 6'(k), pix(k, seed)});
        if (n > 0) sbd.push_back(row);
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while ((sbw.size() != 0 || sbd.size() != 0) && t < 5000) begin
            step(1);
            t++;
        end
        checks++;
        if (t >= 5000) begin
            errors++;
            $display("FAIL %s drain: %0d writes and %0d row_done still expected after 5000 cycles",
                     name, sbw.size(), sbd.size());
        end
        step(6);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: pops expected writes / row completions as the DUT emits them.
    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_en) begin
                bit [15:0] e;
                checks++;
                n_wr++;
                if (sbw.size() == 0) begin
                    errors++;
                    $display("FAIL write: unexpected addr=0x%0h data=0x%0h", wr_addr, wr_data);
                end else begin
                    e = sbw.pop_front();
                    if ({wr_addr, wr_data} !== e) begin
                        errors++;
                        $display("FAIL write: got addr=0x%0h data=0x%0h, expected addr=0x%0h data=0x%0h",
                                 wr_addr, wr_data, e[15:6], e[5:0]);
                    end
                end
            end else if (wr_addr != '0 || wr_data != '0) begin
                checks++;
                errors++;
                $display("FAIL idle_bus: addr=0x%0h data=0x%0h while wr_en=0, expected 0", wr_addr, wr_data);
            end
            if (row_done) begin
                bit [3:0] e;
                checks++;
                if (sbd.size() == 0) begin
                    errors++;
                    $display("FAIL row_done: unexpected pulse row_idx=%0d", row_idx);
                end else begin
                    e = sbd.pop_front();
                    if (row_idx !== e || sbw.size() != 0) begin
                        errors++;
                        $display("FAIL row_done: got row_idx=%0d pending_writes=%0d, expected row_idx=%0d pending_writes=0",
                                 row_idx, sbw.size(), e);
                    end
                end
            end
        end
    end

    vec_t tbl[6];

    initial begin
        int base;
        int t;

        tbl[0] = '{n: 64, row: 4'd3,  seed: 0,  err: 3'b000};
        tbl[1] = '{n: 64, row: 4'd7,  seed: 17, err: 3'b000};
        tbl[2] = '{n: 1,  row: 4'd15, seed: 50, err: 3'b010};
        tbl[3] = '{n: 10, row: 4'd5,  seed: 33, err: 3'b010};
        tbl[4] = '{n: 0,  row: 4'd6,  seed: 0,  err: 3'b010};
        tbl[5] = '{n: 70, row: 4'd9,  seed: 5,  err: 3'b011};

        // Reset state
        step(4);
        chk("reset_wr_en", int'(wr_en), 0);
        chk("reset_row_done", int'(row_done), 0);
        chk("reset_row_idx", int'(row_idx), 0);
        chk("reset_err", int'(err), 0);
        chk("reset_blank", int'(blank), 0);
        rst_n = 1'b1;
        step(4);

        // Blank passes through a two-cycle synchronizer
        hub_blank = 1'b1;
        step(1);
        chk("blank_lat1", int'(blank), 0);
        step(1);
        chk("blank_lat2", int'(blank), 1);
        hub_blank = 1'b0;
        step(3);

        // Table-driven rows: full, single pixel, short, bare latch, overflow
        for (int i = 0; i < 6; i++) begin
            shift_row(tbl[i].n, tbl[i].seed, 2);
            push_row(tbl[i].row, tbl[i].n, tbl[i].seed);
            do_latch(tbl[i].row, 2);
            drain($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_err", i), int'(err), int'(tbl[i].err));
        end

        // Clock rise coincident with latch: that pixel closes the row
        shift_row(3, 40, 2);
        hub_clk = 1'b0;
        set_rgb(pix(3, 40));
        step(2);
        hub_clk   = 1'b1;
        hub_latch = 1'b1;
        hub_row   = 4'd11;
        step(2);
        hub_clk   = 1'b0;
        hub_latch = 1'b0;
        step(2);
        push_row(4'd11, 4, 40);
        drain("simul");
        chk("simul_err", int'(err), 3'b011);

        // Clear errors with reset, then back-to-back rows at panel clk = i_clk/8
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(2);
        chk("rst2_err", int'(err), 0);
        for (int r = 0; r < 16; r++) begin
            shift_row(64, r * 3, 4);
            if (r > 0) chk($sformatf("overlap%0d", r), sbw.size(), 0);
            push_row(4'(r), 64, r * 3);
            do_latch(4'(r), 4);
        end
        drain("b2b");
        chk("b2b_err", int'(err), 0);

        // Overrun: second latch while the first row is still committing
        shift_row(64, 2, 2);
        push_row(4'd1, 64, 2);
        do_latch(4'd1, 2);
        shift_row(5, 60, 2);
        do_latch(4'd2, 2);
        drain("overrun");
        chk("overrun_err", int'(err), 3'b100);
        shift_row(64, 8, 2);
        push_row(4'd13, 64, 8);
        do_latch(4'd13, 2);
        drain("post_overrun");
        chk("post_overrun_err", int'(err), 3'b100);

        // Reset in the middle of a commit, then a fresh row
        shift_row(64, 9, 2);
        push_row(4'd4, 64, 9);
        base = n_wr;
        do_latch(4'd4, 2);
        t = 0;
        while ((n_wr - base) < 20 && t < 500) begin
            step(1);
            t++;
        end
        chk("midreset_reached", int'((n_wr - base) >= 20), 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midreset_wr_en", int'(wr_en), 0);
        chk("midreset_addr", int'(wr_addr), 0);
        chk("midreset_data", int'(wr_data), 0);
        chk("midreset_err", int'(err), 0);
        sbw.delete();
        sbd.delete();
        step(3);
        chk("inreset_wr_en", int'(wr_en), 0);
        rst_n = 1'b1;
        step(3);
        shift_row(64, 21, 2);
        push_row(4'd12, 64, 21);
        do_latch(4'd12, 2);
        drain("fresh");
        chk("fresh_err", int'(err), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
